icache_direct_mapped: RTL and testbench

Direct-mapped instruction cache sitting directly upstream of the issue stage, between it and the memory adaptor. It serves 16/32-bit instruction fetches at halfword-aligned PCs. Hits are answered combinationally in the request cycle. On a miss it runs a one-word refill FSM against the memory adaptor. A 32-bit instruction that straddles two words needs both words present before it is returned.

---
 rtl/icache_direct_mapped_pkg.sv | 16 +
 rtl/icache_direct_mapped_if.sv | 39 +++
 rtl/icache_direct_mapped_tag_data_array.sv | 52 +++++
 rtl/icache_direct_mapped.sv | 127 ++++++++++++
 tb/tb_icache_direct_mapped.sv | 326 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/icache_direct_mapped_pkg.sv
// Shared types and helpers for the direct-mapped instruction cache.
package icache_pkg;

    localparam int XLEN = 32;

    typedef enum logic {
        IDLE,
        REFILL
    } state_t;

    // A halfword whose two low bits are not 2'b11 starts a compressed instruction.
    function automatic logic is_rvc(input logic [15:0] halfword);
        return halfword[1:0] != 2'b11;
    endfunction

endpackage

// File: rtl/icache_direct_mapped_if.sv
// Fetch-side and memory-adaptor-side signals of the instruction cache.
interface icache_direct_mapped_if;
    import icache_pkg::*;

    logic            is_reading;
    logic [XLEN-1:0] read_addr;
    logic            is_ready;
    logic [XLEN-1:0] read_data;
    logic            icache_available;
    logic            request_ins_from_memory_adaptor;
    logic [XLEN-1:0] insaddr_to_be_fetched_from_memory_adaptor;
    logic [XLEN-1:0] ins_fetched_from_memory_adaptor;
    logic            insfetch_task_done;

    modport slave (
        input  is_reading,
        input  read_addr,
        input  ins_fetched_from_memory_adaptor,
        input  insfetch_task_done,
        output is_ready,
        output read_data,
        output icache_available,
        output request_ins_from_memory_adaptor,
        output insaddr_to_be_fetched_from_memory_adaptor
    );

    modport master (
        output is_reading,
        output read_addr,
        output ins_fetched_from_memory_adaptor,
        output insfetch_task_done,
        input  is_ready,
        input  read_data,
        input  icache_available,
        input  request_ins_from_memory_adaptor,
        input  insaddr_to_be_fetched_from_memory_adaptor
    );

endinterface

// File: rtl/icache_direct_mapped_tag_data_array.sv
// Valid/tag/data storage with two combinational lookup ports and one write port.
module icache_tag_data_array
    import icache_pkg::*;
#(
    parameter int INDEX_BITS = 8,
    parameter int TAG_BITS   = 30 - INDEX_BITS
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic [INDEX_BITS-1:0] rd0_index,
    input  logic [TAG_BITS-1:0]   rd0_tag,
    output logic                  rd0_hit,
    output logic [XLEN-1:0]       rd0_data,
    input  logic [INDEX_BITS-1:0] rd1_index,
    input  logic [TAG_BITS-1:0]   rd1_tag,
    output logic                  rd1_hit,
    output logic [XLEN-1:0]       rd1_data,
    input  logic                  wr_en,
    input  logic [INDEX_BITS-1:0] wr_index,
    input  logic [TAG_BITS-1:0]   wr_tag,
    input  logic [XLEN-1:0]       wr_data
);

    localparam int DEPTH = 1 << INDEX_BITS;

    logic [DEPTH-1:0]    valid_q;
    logic [TAG_BITS-1:0] tag_q  [DEPTH];
    logic [XLEN-1:0]     data_q [DEPTH];

    // Valid bits are the only state that reset must clear; a write marks its entry valid.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_index] <= 1'b1;
        end
    end

    // Tag and data need no reset because they are ignored while the valid bit is low.
    always_ff @(posedge clk_in) begin
        if (wr_en) begin
            tag_q[wr_index]  <= wr_tag;
            data_q[wr_index] <= wr_data;
        end
    end

    assign rd0_hit  = valid_q[rd0_index] && (tag_q[rd0_index] == rd0_tag);
    assign rd0_data = data_q[rd0_index];
    assign rd1_hit  = valid_q[rd1_index] && (tag_q[rd1_index] == rd1_tag);
    assign rd1_data = data_q[rd1_index];

endmodule

// File: rtl/icache_direct_mapped.sv
// Direct-mapped instruction cache: same-cycle hits, one-word refills on a miss,
// and straddling 32-bit instructions assembled from two adjacent words.
module icache_direct_mapped
    import icache_pkg::*;
#(
    parameter int INDEX_BITS = 8
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         rdy_in,
    input  logic                         flush_pipline,
    icache_direct_mapped_if.slave        bus
);

    localparam int TAG_BITS = 30 - INDEX_BITS;

    logic [29:0]     word0;
    logic [29:0]     word1;
    logic [29:0]     miss_word;
    logic            hit0;
    logic            hit1;
    logic [XLEN-1:0] data0;
    logic [XLEN-1:0] data1;
    logic [15:0]     half0;
    logic            rvc;
    logic            need_word1;
    logic            all_hit;
    logic [XLEN-1:0] rd_data;
    logic [16:0]     unused_bits;

    state_t          state_q;
    state_t          state_d;
    logic            req_q;
    logic            req_d;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] addr_d;
    logic            wr_en;

    // The second word wraps modulo 2^30, so the last halfword of memory pairs with word 0.
    assign word0     = bus.read_addr[31:2];
    assign word1     = word0 + 30'd1;
    assign half0     = bus.read_addr[1] ? data0[31:16] : data0[15:0];
    assign rvc       = is_rvc(half0);
    assign need_word1 = !rvc && bus.read_addr[1];
    assign all_hit   = hit0 && (!need_word1 || hit1);
    assign miss_word = hit0 ? word1 : word0;

    // Bit 0 of the PC is always zero and only the low half of the second word is ever used.
    assign unused_bits = {bus.read_addr[0], data1[31:16]};

    icache_tag_data_array #(
        .INDEX_BITS(INDEX_BITS),
        .TAG_BITS  (TAG_BITS)
    ) u_array (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .rd0_index(word0[INDEX_BITS-1:0]),
        .rd0_tag  (word0[29:INDEX_BITS]),
        .rd0_hit  (hit0),
        .rd0_data (data0),
        .rd1_index(word1[INDEX_BITS-1:0]),
        .rd1_tag  (word1[29:INDEX_BITS]),
        .rd1_hit  (hit1),
        .rd1_data (data1),
        .wr_en    (wr_en),
        .wr_index (addr_q[INDEX_BITS+1:2]),
        .wr_tag   (addr_q[31:INDEX_BITS+2]),
        .wr_data  (bus.ins_fetched_from_memory_adaptor)
    );

    // Assemble the instruction: compressed in the low half, otherwise one word or a straddle.
    always_comb begin
        rd_data = data0;
        if (rvc) begin
            rd_data = {16'h0000, half0};
        end else if (bus.read_addr[1]) begin
            rd_data = {data1[15:0], data0[31:16]};
        end
    end

    // Refill FSM state and the registered request towards the memory adaptor.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
        end
    end

    // Next state: everything holds while rdy_in is low; a flush only blocks new misses,
    // an outstanding refill still completes and is written since its data is correct.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        addr_d  = addr_q;
        wr_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (rdy_in && bus.is_reading && !flush_pipline && !all_hit) begin
                    state_d = REFILL;
                    req_d   = 1'b1;
                    addr_d  = {miss_word, 2'b00};
                end
            end
            REFILL: begin
                if (rdy_in && bus.insfetch_task_done) begin
                    wr_en   = 1'b1;
                    req_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.is_ready = rst_in && (state_q == IDLE) && rdy_in && bus.is_reading
                          && !flush_pipline && all_hit;
    assign bus.read_data = rd_data;
    assign bus.icache_available = rst_in && (state_q == IDLE);
    assign bus.request_ins_from_memory_adaptor = req_q;
    assign bus.insaddr_to_be_fetched_from_memory_adaptor = addr_q;

endmodule

// File: tb/tb_icache_direct_mapped.sv
// Self-checking bench for icache_direct_mapped: directed vector table, hand-written
// flush/freeze sequences, and randomized fetches against a residency-map reference model.
module tb_icache_direct_mapped;
    import icache_pkg::*;

    localparam int INDEX_BITS = 8;
    localparam int NUM_RANDOM = 60;

    logic clk_in = 1'b0;
    logic rst_in;
    logic rdy_in;
    logic flush_pipline;

    int checks = 0;
    int errors = 0;

    icache_direct_mapped_if bus();

    icache_direct_mapped #(.INDEX_BITS(INDEX_BITS)) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .rdy_in       (rdy_in),
        .flush_pipline(flush_pipline),
        .bus          (bus)
    );

    always #5 clk_in = ~clk_in;

    // Backing memory: explicit words where a test needs specific content, a hash elsewhere.
    logic [31:0] mem [logic [29:0]];
    // Which word address currently occupies each cache index.
    logic [29:0] resident [int];

    typedef struct {
        logic [31:0] addr;
        int          delay;
        logic [31:0] exp_data;
        int          exp_nref;
        logic [31:0] exp_ra0;
        logic [31:0] exp_ra1;
    } vec_t;

    vec_t vecs [9];

    function automatic logic [31:0] memRead(input logic [29:0] w);
        logic [31:0] x;
        if (mem.exists(w)) return mem[w];
        x = {2'b00, w};
        return (x * 32'h9E37_79B1) ^ (x << 13);
    endfunction

    function automatic logic [15:0] firstHalf(input logic [31:0] addr);
        logic [31:0] a;
        a = memRead(addr[31:2]);
        return addr[1] ? a[31:16] : a[15:0];
    endfunction

    function automatic logic needsSecond(input logic [31:0] addr);
        logic [15:0] h;
        h = firstHalf(addr);
        return (h[1:0] == 2'b11) && addr[1];
    endfunction

    function automatic logic [31:0] expInstr(input logic [31:0] addr);
        logic [29:0] w0;
        logic [29:0] w1;
        logic [31:0] a;
        logic [31:0] b;
        logic [15:0] h;
        w0 = addr[31:2];
        w1 = w0 + 30'd1;
        a  = memRead(w0);
        b  = memRead(w1);
        h  = firstHalf(addr);
        if (h[1:0] != 2'b11) return {16'h0000, h};
        if (addr[1]) return {b[15:0], a[31:16]};
        return a;
    endfunction

    function automatic int indexOf(input logic [29:0] w);
        return int'(w % (30'd1 << INDEX_BITS));
    endfunction

    function automatic logic isResident(input logic [29:0] w);
        return resident.exists(indexOf(w)) && (resident[indexOf(w)] == w);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    task automatic doReset();
        @(posedge clk_in); #1;
        rst_in = 1'b0;
        bus.is_reading = 1'b1;
        bus.read_addr = 32'h0;
        @(negedge clk_in);
        checkOutput("rst_ready", {31'b0, bus.is_ready}, 32'h0);
        checkOutput("rst_avail", {31'b0, bus.icache_available}, 32'h0);
        checkOutput("rst_req", {31'b0, bus.request_ins_from_memory_adaptor}, 32'h0);
        checkOutput("rst_raddr", bus.insaddr_to_be_fetched_from_memory_adaptor, 32'h0);
        @(posedge clk_in); #1;
        rst_in = 1'b1;
        bus.is_reading = 1'b0;
        resident.delete();
    endtask

    // Drives one fetch to completion, serving every refill the cache asks for.
    task automatic applyStimulus(input logic [31:0] addr, input int delay,
                                 output logic [31:0] data, output int nref,
                                 output logic [31:0] ra0, output logic [31:0] ra1);
        logic got;
        got  = 1'b0;
        data = 32'h0;
        nref = 0;
        ra0  = 32'h1;
        ra1  = 32'h1;
        @(posedge clk_in); #1;
        bus.is_reading = 1'b1;
        bus.read_addr  = addr;
        for (int it = 0; it < 3 && !got; it++) begin
            @(negedge clk_in);
            checkOutput("lookup_avail", {31'b0, bus.icache_available}, 32'h1);
            if (bus.is_ready) begin
                checkOutput("hit_noreq", {31'b0, bus.request_ins_from_memory_adaptor}, 32'h0);
                data = bus.read_data;
                got  = 1'b1;
            end else begin
                @(negedge clk_in);
                checkOutput("miss_req", {31'b0, bus.request_ins_from_memory_adaptor}, 32'h1);
                checkOutput("miss_avail", {31'b0, bus.icache_available}, 32'h0);
                if (nref == 0) ra0 = bus.insaddr_to_be_fetched_from_memory_adaptor;
                else           ra1 = bus.insaddr_to_be_fetched_from_memory_adaptor;
                nref++;
                repeat (delay) @(posedge clk_in);
                @(posedge clk_in); #1;
                bus.insfetch_task_done = 1'b1;
                bus.ins_fetched_from_memory_adaptor =
                    memRead(bus.insaddr_to_be_fetched_from_memory_adaptor[31:2]);
                @(posedge clk_in); #1;
                bus.insfetch_task_done = 1'b0;
            end
        end
        checkOutput("ready_seen", {31'b0, got}, 32'h1);
        @(posedge clk_in); #1;
        bus.is_reading = 1'b0;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [31:0] data;
        logic [31:0] ra0;
        logic [31:0] ra1;
        logic [31:0] addr;
        logic [29:0] w0;
        logic [29:0] w1;
        logic [31:0] e0;
        logic [31:0] e1;
        logic        half_sel;
        logic        seen_ready;
        logic        req_dropped;
        int          nref;
        int          nexp;

        rst_in = 1'b0;
        rdy_in = 1'b1;
        flush_pipline = 1'b0;
        bus.is_reading = 1'b0;
        bus.read_addr = 32'h0;
        bus.insfetch_task_done = 1'b0;
        bus.ins_fetched_from_memory_adaptor = 32'h0;

        mem[30'h0]        = 32'h0050_0093;
        mem[30'h1]        = 32'h0093_0000;
        mem[30'h2]        = 32'h0000_0050;
        mem[30'h100]      = 32'h00A0_0513;
        mem[30'h3FFF_FFFF] = 32'h0013_0000;

        vecs[0] = '{32'h0000_0000, 0, 32'h0050_0093, 1, 32'h0000_0000, 32'h1};
        vecs[1] = '{32'h0000_0000, 0, 32'h0050_0093, 0, 32'h1,         32'h1};
        vecs[2] = '{32'h0000_0006, 1, 32'h0050_0093, 2, 32'h0000_0004, 32'h0000_0008};
        vecs[3] = '{32'h0000_0400, 2, 32'h00A0_0513, 1, 32'h0000_0400, 32'h1};
        vecs[4] = '{32'h0000_0000, 0, 32'h0050_0093, 1, 32'h0000_0000, 32'h1};
        vecs[5] = '{32'h0000_0004, 0, 32'h0000_0000, 0, 32'h1,         32'h1};
        vecs[6] = '{32'hFFFF_FFFE, 0, 32'h0093_0013, 1, 32'hFFFF_FFFC, 32'h1};
        vecs[7] = '{32'h0000_0000, 0, 32'h4505_0093, 1, 32'h0000_0000, 32'h1};
        vecs[8] = '{32'h0000_0002, 0, 32'h0000_4505, 0, 32'h1,         32'h1};

        doReset();

        for (int i = 0; i < 9; i++) begin
            if (i == 7) begin
                mem[30'h0] = 32'h4505_0093;
                doReset();
            end
            applyStimulus(vecs[i].addr, vecs[i].delay, data, nref, ra0, ra1);
            checkOutput($sformatf("vec%0d_data", i), data, vecs[i].exp_data);
            checkOutput($sformatf("vec%0d_nref", i), nref, vecs[i].exp_nref);
            checkOutput($sformatf("vec%0d_ra0", i), ra0, vecs[i].exp_ra0);
            checkOutput($sformatf("vec%0d_ra1", i), ra1, vecs[i].exp_ra1);
        end

        // Flush held across a refill, including the done cycle and one IDLE cycle after it.
        @(posedge clk_in); #1;
        bus.is_reading = 1'b1;
        bus.read_addr = 32'h10;
        @(negedge clk_in);
        checkOutput("flush_miss", {31'b0, bus.is_ready}, 32'h0);
        @(posedge clk_in); #1;
        flush_pipline = 1'b1;
        @(negedge clk_in);
        checkOutput("flush_req", {31'b0, bus.request_ins_from_memory_adaptor}, 32'h1);
        checkOutput("flush_raddr", bus.insaddr_to_be_fetched_from_memory_adaptor, 32'h10);
        seen_ready = 1'b0;
        req_dropped = 1'b0;
        repeat (2) begin
            @(posedge clk_in); #1;
            if (bus.is_ready) seen_ready = 1'b1;
            if (!bus.request_ins_from_memory_adaptor) req_dropped = 1'b1;
        end
        bus.insfetch_task_done = 1'b1;
        bus.ins_fetched_from_memory_adaptor = memRead(30'h4);
        @(posedge clk_in); #1;
        bus.insfetch_task_done = 1'b0;
        @(negedge clk_in);
        checkOutput("flush_avail", {31'b0, bus.icache_available}, 32'h1);
        checkOutput("flush_noready", {31'b0, bus.is_ready}, 32'h0);
        checkOutput("flush_reqdrop", {31'b0, bus.request_ins_from_memory_adaptor}, 32'h0);
        @(posedge clk_in); #1;
        flush_pipline = 1'b0;
        bus.is_reading = 1'b0;
        checkOutput("flush_seen_ready", {31'b0, seen_ready}, 32'h0);
        checkOutput("flush_req_held", {31'b0, req_dropped}, 32'h0);
        applyStimulus(32'h10, 0, data, nref, ra0, ra1);
        checkOutput("flush_after_data", data, expInstr(32'h10));
        checkOutput("flush_after_nref", nref, 0);

        // A done pulse while rdy_in is low must be ignored entirely.
        @(posedge clk_in); #1;
        bus.is_reading = 1'b1;
        bus.read_addr = 32'h20;
        @(negedge clk_in);
        @(negedge clk_in);
        checkOutput("frz_req", {31'b0, bus.request_ins_from_memory_adaptor}, 32'h1);
        @(posedge clk_in); #1;
        rdy_in = 1'b0;
        bus.insfetch_task_done = 1'b1;
        bus.ins_fetched_from_memory_adaptor = 32'hDEAD_BEEF;
        @(posedge clk_in); #1;
        bus.insfetch_task_done = 1'b0;
        @(negedge clk_in);
        checkOutput("frz_req_hold", {31'b0, bus.request_ins_from_memory_adaptor}, 32'h1);
        checkOutput("frz_avail", {31'b0, bus.icache_available}, 32'h0);
        @(posedge clk_in); #1;
        rdy_in = 1'b1;
        bus.insfetch_task_done = 1'b1;
        bus.ins_fetched_from_memory_adaptor = memRead(30'h8);
        @(posedge clk_in); #1;
        bus.insfetch_task_done = 1'b0;
        @(negedge clk_in);
        checkOutput("frz_ready", {31'b0, bus.is_ready}, 32'h1);
        checkOutput("frz_data", bus.read_data, expInstr(32'h20));
        @(posedge clk_in); #1;
        bus.is_reading = 1'b0;

        // A resident word still reports not-ready while rdy_in is low.
        rdy_in = 1'b0;
        bus.is_reading = 1'b1;
        bus.read_addr = 32'h0;
        @(negedge clk_in);
        checkOutput("rdy_low_ready", {31'b0, bus.is_ready}, 32'h0);
        checkOutput("rdy_low_req", {31'b0, bus.request_ins_from_memory_adaptor}, 32'h0);
        @(posedge clk_in); #1;
        rdy_in = 1'b1;
        @(negedge clk_in);
        checkOutput("rdy_high_ready", {31'b0, bus.is_ready}, 32'h1);
        checkOutput("rdy_high_data", bus.read_data, 32'h4505_0093);
        @(posedge clk_in); #1;
        bus.is_reading = 1'b0;

        // Randomized fetches over a few conflicting tags plus the wrap-around address.
        doReset();
        for (int n = 0; n < NUM_RANDOM; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                w0 = 30'h3FFF_FFFF;
            end else begin
                w0 = (30'($urandom_range(0, 3)) << INDEX_BITS) | 30'($urandom_range(0, 15));
            end
            half_sel = 1'($urandom_range(0, 1));
            addr = {w0, half_sel, 1'b0};
            w1 = w0 + 30'd1;
            nexp = 0;
            e0 = 32'h1;
            e1 = 32'h1;
            if (!isResident(w0)) begin
                e0 = {w0, 2'b00};
                nexp++;
            end
            if (needsSecond(addr) && !isResident(w1)) begin
                if (nexp == 0) e0 = {w1, 2'b00};
                else           e1 = {w1, 2'b00};
                nexp++;
            end
            applyStimulus(addr, int'($urandom_range(0, 2)), data, nref, ra0, ra1);
            checkOutput($sformatf("rnd%0d_data@%h", n, addr), data, expInstr(addr));
            checkOutput($sformatf("rnd%0d_nref@%h", n, addr), nref, nexp);
            checkOutput($sformatf("rnd%0d_ra0@%h", n, addr), ra0, e0);
            checkOutput($sformatf("rnd%0d_ra1@%h", n, addr), ra1, e1);
            resident[indexOf(w0)] = w0;
            if (needsSecond(addr)) resident[indexOf(w1)] = w1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
